// File: rtl/ica_bus_responder_if.sv
// Bus bundle between the ICA/DCA word-fetch requesters, the responder and the VRAM read port.
// The responder uses the slave view; requesters and the memory side use the master view.
interface ica_bus_responder_if;
  logic [21:0] req0_address;
  logic        req0_as;
  logic [15:0] req0_din;
  logic        req0_bus_ack;
  logic [21:0] req1_address;
  logic        req1_as;
  logic [15:0] req1_din;
  logic        req1_bus_ack;
  logic [20:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        timeout_err;

  modport slave (
    input  req0_address, req0_as, req1_address, req1_as, mem_rdata, mem_valid,
    output req0_din, req0_bus_ack, req1_din, req1_bus_ack, mem_addr, mem_rd, timeout_err
  );

  modport master (
    output req0_address, req0_as, req1_address, req1_as, mem_rdata, mem_valid,
    input  req0_din, req0_bus_ack, req1_din, req1_bus_ack, mem_addr, mem_rd, timeout_err
  );
endinterface

// File: rtl/ica_bus_responder.sv
// Round-robin word-fetch responder for the two ICA/DCA units onto a single VRAM read port.
// A fetch that never completes is answered with 16'h0000 (STOP) after TIMEOUT cycles.
module ica_bus_responder #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ica_bus_responder_if.slave   bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          rr_q, rr_d;
  logic [1:0]    gap_q, gap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [20:0]   mem_addr_q, mem_addr_d;
  logic          mem_rd_q, mem_rd_d;
  logic [1:0]    ack_q, ack_d;
  logic [15:0]   din0_q, din0_d;
  logic [15:0]   din1_q, din1_d;
  logic          tmo_q, tmo_d;

  logic [1:0]    elig;
  logic          gnt;
  logic          grant_as;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = bus.req0_address[0] ^ bus.req1_address[0];

  // gap masks a unit for the cycle after its ack, while its address is still stale
  assign elig     = {bus.req1_as & ~gap_q[1], bus.req0_as & ~gap_q[0]};
  assign grant_as = grant_q ? bus.req1_as : bus.req0_as;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    gap_d      = '0;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    ack_d      = '0;
    din0_d     = din0_q;
    din1_d     = din1_q;
    tmo_d      = 1'b0;
    gnt        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (elig != 2'b00) begin
          gnt        = (elig == 2'b11) ? rr_q : elig[1];
          grant_d    = gnt;
          rr_d       = ~gnt;
          mem_addr_d = gnt ? bus.req1_address[21:1] : bus.req0_address[21:1];
          mem_rd_d   = 1'b1;
          cnt_d      = CW'(1);
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        // data arriving on the timeout cycle takes precedence over the STOP word
        if (bus.mem_valid) begin
          if (grant_as) begin
            ack_d[grant_q] = 1'b1;
            gap_d[grant_q] = 1'b1;
            if (grant_q) din1_d = bus.mem_rdata;
            else         din0_d = bus.mem_rdata;
          end
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          tmo_d          = 1'b1;
          gap_d[grant_q] = 1'b1;
          if (grant_as) begin
            ack_d[grant_q] = 1'b1;
            if (grant_q) din1_d = '0;
            else         din0_d = '0;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      gap_q      <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      ack_q      <= '0;
      din0_q     <= '0;
      din1_q     <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      gap_q      <= gap_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      ack_q      <= ack_d;
      din0_q     <= din0_d;
      din1_q     <= din1_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.req0_din     = din0_q;
  assign bus.req1_din     = din1_q;
  assign bus.req0_bus_ack = ack_q[0];
  assign bus.req1_bus_ack = ack_q[1];
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.timeout_err  = tmo_q;

endmodule

// File: tb/tb_ica_bus_responder.sv
// Self-checking bench for ica_bus_responder: table of single fetches, then burst,
// contention, timeout, abort and reset-in-WAIT sequences against a latency-programmable VRAM model.
module tb_ica_bus_responder;

  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ica_bus_responder_if bus ();

  ica_bus_responder #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int unsigned unit;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int unsigned unit;
    logic [21:0] addr;
    int unsigned lat;
    logic [20:0] maddr;
    logic [15:0] data;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sb[$];
  logic [15:0] exp_din [2];
  int unsigned ack_cnt = 0, tmo_cnt = 0, ack_cyc = 0;

  bit          mem_en = 1'b1;
  int unsigned mem_lat = 1;
  int unsigned stray_seq = 0;
  logic [20:0] last_rd_addr = '0;
  int unsigned rd_cnt = 0, rd_cyc = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // VRAM: word at address a reads as a[15:0] + 16'h1034, so 21'h200 -> 16'h1234
  task automatic mem_model();
    bit          pend = 1'b0;
    int unsigned pcnt = 0;
    logic [15:0] pdata = '0;
    int unsigned stray_done = 0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_valid = 1'b0;
      if (stray_seq != stray_done) begin
        stray_done    = stray_seq;
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 16'hBEEF;
      end else if (pend) begin
        if (pcnt <= 1) begin
          bus.mem_valid = 1'b1;
          bus.mem_rdata = pdata;
          pend          = 1'b0;
        end else begin
          pcnt--;
        end
      end
      if (bus.mem_rd) begin
        rd_cnt++;
        rd_cyc       = cyc;
        last_rd_addr = bus.mem_addr;
        if (mem_en) begin
          pend  = 1'b1;
          pcnt  = mem_lat;
          pdata = bus.mem_addr[15:0] + 16'h1034;
        end
      end
    end
  endtask

  task automatic monitor();
    logic [1:0]  ack;
    logic [15:0] din [2];
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_din[0] = '0;
        exp_din[1] = '0;
      end
      if (bus.timeout_err) tmo_cnt++;
      ack    = {bus.req1_bus_ack, bus.req0_bus_ack};
      din[0] = bus.req0_din;
      din[1] = bus.req1_din;
      if (ack != 2'b00) chk("ack_exclusive", {31'd0, ack == 2'b11}, 32'd0);
      for (int k = 0; k < 2; k++) begin
        if (ack[k]) begin
          ack_cnt++;
          ack_cyc = cyc;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack unit=%0d din=%h required=no_ack", k, din[k]);
          end else begin
            e = sb.pop_front();
            chk("ack_unit", k, e.unit);
            chk("ack_din", {16'd0, din[k]}, {16'd0, e.data});
            exp_din[k] = e.data;
            chk("held_din", {16'd0, din[1-k]}, {16'd0, exp_din[1-k]});
          end
        end
      end
    end
  endtask

  task automatic drive(input int unsigned u, input bit as, input logic [21:0] a);
    if (u == 0) begin
      bus.req0_as      = as;
      bus.req0_address = a;
    end else begin
      bus.req1_as      = as;
      bus.req1_address = a;
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int unsigned budget, input string tag);
    int unsigned n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk({tag, "_drain_timeout"}, sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_rd(input int unsigned r0, input string tag);
    int unsigned n = 0;
    while (rd_cnt == r0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rd_cnt == r0) chk({tag, "_mem_rd_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack0"}, {31'd0, bus.req0_bus_ack}, 32'd0);
    chk({tag, "_ack1"}, {31'd0, bus.req1_bus_ack}, 32'd0);
    chk({tag, "_din0"}, {16'd0, bus.req0_din}, 32'd0);
    chk({tag, "_din1"}, {16'd0, bus.req1_din}, 32'd0);
    chk({tag, "_mem_rd"}, {31'd0, bus.mem_rd}, 32'd0);
    chk({tag, "_mem_addr"}, {11'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_timeout_err"}, {31'd0, bus.timeout_err}, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt [6];
    int unsigned s, r0, r1, a0, t0;

    exp_din[0] = '0;
    exp_din[1] = '0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);

    vt[0] = '{0, 22'h000400, 1, 21'h000200, 16'h1234};
    vt[1] = '{1, 22'h000404, 2, 21'h000202, 16'h1236};
    vt[2] = '{0, 22'h3FFFFF, 3, 21'h1FFFFF, 16'h1033};
    vt[3] = '{1, 22'h000001, 1, 21'h000000, 16'h1034};
    vt[4] = '{0, 22'h2AAAAA, 5, 21'h155555, 16'h6589};
    vt[5] = '{1, 22'h155554, 7, 21'h0AAAAA, 16'hBADE};

    fork
      mem_model();
      monitor();
    join_none

    do_reset();
    idle(1);

    for (int i = 0; i < 6; i++) begin
      mem_lat = vt[i].lat;
      s = cyc;
      sb.push_back('{vt[i].unit, vt[i].data});
      drive(vt[i].unit, 1'b1, vt[i].addr);
      wait_drain(40, "vec");
      chk("vec_latency", ack_cyc - s, vt[i].lat + 2);
      chk("vec_mem_addr", {11'd0, last_rd_addr}, {11'd0, vt[i].maddr});
      drive(vt[i].unit, 1'b0, vt[i].addr);
      idle(3);
    end

    // two-word burst with as held; address advances only after the ack is sampled
    mem_lat = 1;
    r0 = rd_cnt;
    sb.push_back('{0, 16'h1234});
    drive(0, 1'b1, 22'h000400);
    wait_drain(20, "burst1");
    @(posedge clk);
    #1;
    sb.push_back('{0, 16'h1235});
    bus.req0_address = 22'h000402;
    wait_drain(20, "burst2");
    chk("burst_mem_addr", {11'd0, last_rd_addr}, 32'h201);
    drive(0, 1'b0, 22'h000402);
    idle(4);
    chk("burst_rd_count", rd_cnt - r0, 32'd2);

    // contention straight after reset: round robin starts at unit 0
    do_reset();
    mem_lat = 1;
    r0 = rd_cnt;
    sb.push_back('{0, 16'h1234});
    sb.push_back('{1, 16'h1236});
    sb.push_back('{0, 16'h1234});
    sb.push_back('{1, 16'h1236});
    drive(0, 1'b1, 22'h000400);
    drive(1, 1'b1, 22'h000404);
    wait_drain(60, "contend");
    drive(0, 1'b0, 22'h000400);
    drive(1, 1'b0, 22'h000404);
    idle(4);
    chk("contend_rd_count", rd_cnt - r0, 32'd4);

    // timeout: memory silent, STOP word returned TIMEOUT cycles after mem_rd
    mem_en = 1'b0;
    t0 = tmo_cnt;
    sb.push_back('{0, 16'h0000});
    drive(0, 1'b1, 22'h000400);
    wait_drain(30, "tmo");
    chk("tmo_latency", ack_cyc - rd_cyc, TMO);
    chk("tmo_err_count", tmo_cnt - t0, 32'd1);
    drive(0, 1'b0, 22'h000400);
    mem_en = 1'b1;
    idle(2);
    a0 = ack_cnt;
    stray_seq++;
    idle(4);
    chk("late_valid_no_ack", ack_cnt - a0, 32'd0);
    chk("late_valid_din0", {16'd0, bus.req0_din}, 32'd0);

    // abort: unit 1 drops as while its read is outstanding
    mem_lat = 4;
    r0 = rd_cnt;
    a0 = ack_cnt;
    t0 = tmo_cnt;
    drive(1, 1'b1, 22'h000408);
    wait_rd(r0, "abort");
    drive(1, 1'b0, 22'h000408);
    idle(12);
    chk("abort_no_ack", ack_cnt - a0, 32'd0);
    chk("abort_din1_held", {16'd0, bus.req1_din}, {16'd0, exp_din[1]});
    chk("abort_no_timeout", tmo_cnt - t0, 32'd0);
    mem_lat = 2;
    sb.push_back('{0, 16'h1236});
    drive(0, 1'b1, 22'h000404);
    wait_drain(20, "post_abort");
    chk("post_abort_mem_addr", {11'd0, last_rd_addr}, 32'h202);
    drive(0, 1'b0, 22'h000404);
    idle(3);

    // reset while in WAIT; the memory answer lands after reset and must be dropped
    mem_lat = 6;
    r0 = rd_cnt;
    drive(0, 1'b1, 22'h000400);
    wait_rd(r0, "rst_wait");
    reset_n = 1'b0;
    drive(0, 1'b0, 22'h000400);
    @(posedge clk);
    @(negedge clk);
    chk_zero("mid_wait_reset");
    #1;
    reset_n = 1'b1;
    a0 = ack_cnt;
    r1 = rd_cnt;
    idle(10);
    chk("post_reset_no_ack", ack_cnt - a0, 32'd0);
    chk("post_reset_no_rd", rd_cnt - r1, 32'd0);
    chk("post_reset_din0", {16'd0, bus.req0_din}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
